// File: rtl/matrix_pkg.sv
// matrix_pkg: shared field layout and pixel repacking for the 8x8 RGB matrix link
package matrix_pkg;
    localparam int ROWS        = 8;
    localparam int COLS        = 8;
    localparam int ROW_SEL_MSB = 31;
    localparam int ROW_SEL_LSB = 24;
    localparam int R_LSB       = 16;
    localparam int G_LSB       = 8;
    localparam int B_LSB       = 0;
    localparam int PIX_W       = 4;
    localparam int PIX_R       = 2;
    localparam int PIX_G       = 1;
    localparam int PIX_B       = 0;

    // Pixel c lands in nibble c as {0, R, G, B}.
    function automatic logic [31:0] repack(input logic [23:0] rgb);
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < COLS; c++) begin
            w[PIX_W*c+PIX_R] = rgb[R_LSB+c];
            w[PIX_W*c+PIX_G] = rgb[G_LSB+c];
            w[PIX_W*c+PIX_B] = rgb[B_LSB+c];
        end
        return w;
    endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser with a third stage for rising-edge detection
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [2:0] s;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) s <= '0;
        else          s <= {s[1:0], d};
    assign q    = s[1];
    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/matrix_shift_rx.sv
// matrix_shift_rx: deserialises the matrix link into a shadow frame buffer read over Wishbone
module matrix_shift_rx
    import matrix_pkg::*;
#(
    parameter int SHIFT_BITS = 32,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_matrix_clk,
    input  logic             i_matrix_latch,
    input  logic             i_matrix_mosi,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_addr,
    input  logic [3:0]       i_wb_sel,
    input  logic [31:0]      i_wb_wdata,
    output logic             o_wb_ack,
    output logic             o_wb_stall,
    output logic [31:0]      o_wb_rdata,
    output logic [ROWS-1:0]  o_row_valid,
    output logic             o_frame_done,
    output logic [ERR_W-1:0] o_err_count
);
    localparam int CNT_W = $clog2(SHIFT_BITS + 2);

    logic sclk_s, sclk_rise, latch_s, latch_rise, mosi_s, mosi_rise;
    logic [SHIFT_BITS-1:0] shreg, word;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0] row;
    logic accept, reject;
    logic [31:0] fb [ROWS];
    logic unused_ok;

    sync_edge u_sclk  (.clk(clk), .reset_n(reset_n), .d(i_matrix_clk),   .q(sclk_s),  .rise(sclk_rise));
    sync_edge u_latch (.clk(clk), .reset_n(reset_n), .d(i_matrix_latch), .q(latch_s), .rise(latch_rise));
    sync_edge u_mosi  (.clk(clk), .reset_n(reset_n), .d(i_matrix_mosi),  .q(mosi_s),  .rise(mosi_rise));

    assign unused_ok  = ^{i_wb_sel, i_wb_wdata, i_wb_we, mosi_rise, latch_s, sclk_s};
    assign o_wb_stall = 1'b0;

    // A shift landing in the latch cycle is folded into the word being judged.
    always_comb begin
        word   = sclk_rise ? {shreg[SHIFT_BITS-2:0], mosi_s} : shreg;
        cnt_nx = (sclk_rise && cnt != CNT_W'(SHIFT_BITS + 1)) ? cnt + 1'b1 : cnt;
        row    = '0;
        for (int r = 0; r < ROWS; r++)
            if (word[ROW_SEL_LSB+r]) row = 3'(r);
        accept = latch_rise && cnt_nx == CNT_W'(SHIFT_BITS) && $onehot(word[ROW_SEL_MSB:ROW_SEL_LSB]);
        reject = latch_rise && !accept;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg        <= '0;
            cnt          <= '0;
            o_row_valid  <= '0;
            o_frame_done <= 1'b0;
            o_err_count  <= '0;
            o_wb_ack     <= 1'b0;
            o_wb_rdata   <= '0;
            for (int r = 0; r < ROWS; r++) fb[r] <= '0;
        end else begin
            shreg        <= word;
            cnt          <= latch_rise ? '0 : cnt_nx;
            o_frame_done <= accept && row == 3'd7;
            if (accept) begin
                fb[row]          <= repack(word[23:0]);
                o_row_valid[row] <= 1'b1;
            end
            if (reject && o_err_count != '1) o_err_count <= o_err_count + 1'b1;
            o_wb_ack <= i_wb_cyc & i_wb_stb;
            if (i_wb_cyc & i_wb_stb) o_wb_rdata <= fb[i_wb_addr];
        end
    end
endmodule

// File: tb/tb_matrix_shift_rx.sv
// tb_matrix_shift_rx: directed table-driven bench for the matrix link receiver
module tb_matrix_shift_rx;
    logic clk = 0, reset_n = 0;
    logic mclk = 0, mlatch = 0, mosi = 0;
    logic cyc = 0, stb = 0, we = 0;
    logic [2:0] addr = 0;
    logic [3:0] sel = 4'hF;
    logic [31:0] wdata = 0;
    logic ack, stall, frame_done;
    logic [31:0] rdata;
    logic [7:0] row_valid, err_count;
    int total = 0, bad = 0, fd_cnt = 0;

    typedef struct {
        logic [31:0] w;
        int          n;
        logic [2:0]  rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_valid;
        logic [7:0]  exp_err;
        int          exp_fd;
    } vec_t;
    vec_t tv [12];

    matrix_shift_rx dut (
        .clk(clk), .reset_n(reset_n),
        .i_matrix_clk(mclk), .i_matrix_latch(mlatch), .i_matrix_mosi(mosi),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_sel(sel), .i_wb_wdata(wdata),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_rdata(rdata),
        .o_row_valid(row_valid), .o_frame_done(frame_done), .o_err_count(err_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(3);
        mclk = 1;
        tick(3);
        mclk = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(i < 32 ? w[i] : 1'b0);
        tick(3);
    endtask

    task automatic do_latch();
        mlatch = 1;
        tick(3);
        mlatch = 0;
        tick(5);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        cyc = 1; stb = 1; we = 0; addr = a;
        tick(1);
        cyc = 0; stb = 0;
        chk({name, "_ack"}, {31'b0, ack}, 32'd1);
        chk(name, rdata, exp);
    endtask

    initial begin
        tv[0]  = '{32'h04FF000F, 32, 3'd2, 32'h44445555, 8'h04, 8'd0, 0};
        tv[1]  = '{32'h02FFFFFF, 31, 3'd1, 32'h00000000, 8'h04, 8'd1, 0};
        tv[2]  = '{32'h02FFFFFF, 33, 3'd1, 32'h00000000, 8'h04, 8'd2, 0};
        tv[3]  = '{32'h03FFFFFF, 32, 3'd0, 32'h00000000, 8'h04, 8'd3, 0};
        tv[4]  = '{32'h01818181, 32, 3'd0, 32'h70000007, 8'h05, 8'd3, 0};
        tv[5]  = '{32'h02818181, 32, 3'd1, 32'h70000007, 8'h07, 8'd3, 0};
        tv[6]  = '{32'h04818181, 32, 3'd2, 32'h70000007, 8'h07, 8'd3, 0};
        tv[7]  = '{32'h08818181, 32, 3'd3, 32'h70000007, 8'h0F, 8'd3, 0};
        tv[8]  = '{32'h10818181, 32, 3'd4, 32'h70000007, 8'h1F, 8'd3, 0};
        tv[9]  = '{32'h20818181, 32, 3'd5, 32'h70000007, 8'h3F, 8'd3, 0};
        tv[10] = '{32'h40818181, 32, 3'd6, 32'h70000007, 8'h7F, 8'd3, 0};
        tv[11] = '{32'h80818181, 32, 3'd7, 32'h70000007, 8'hFF, 8'd3, 1};

        tick(3);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_fd", {31'b0, frame_done}, 32'd0);
        reset_n = 1;
        tick(2);
        for (int r = 0; r < 8; r++) rd(3'(r), 32'h0, $sformatf("rst_row%0d", r));
        chk("rst_valid", {24'b0, row_valid}, 32'h0);
        chk("rst_err", {24'b0, err_count}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            send_word(tv[i].w, tv[i].n);
            do_latch();
            rd(tv[i].rd, tv[i].exp_rd, $sformatf("tv%0d_row", i));
            chk($sformatf("tv%0d_valid", i), {24'b0, row_valid}, {24'b0, tv[i].exp_valid});
            chk($sformatf("tv%0d_err", i), {24'b0, err_count}, {24'b0, tv[i].exp_err});
            chk($sformatf("tv%0d_fd", i), 32'(fd_cnt), 32'(tv[i].exp_fd));
        end
        for (int r = 0; r < 8; r++) rd(3'(r), 32'h70000007, $sformatf("frame_row%0d", r));

        cyc = 1; stb = 1; we = 0; addr = 1;
        tick(1);
        chk("b2b_ack1", {31'b0, ack}, 32'd1);
        chk("b2b_rd1", rdata, 32'h70000007);
        chk("b2b_stall", {31'b0, stall}, 32'd0);
        addr = 2;
        tick(1);
        chk("b2b_ack2", {31'b0, ack}, 32'd1);
        chk("b2b_rd2", rdata, 32'h70000007);
        addr = 3;
        tick(1);
        chk("b2b_ack3", {31'b0, ack}, 32'd1);
        chk("b2b_rd3", rdata, 32'h70000007);
        we = 1; addr = 4; wdata = 32'h0;
        tick(1);
        cyc = 0; stb = 0; we = 0;
        chk("b2b_ack_wr", {31'b0, ack}, 32'd1);
        tick(1);
        chk("b2b_ack_idle", {31'b0, ack}, 32'd0);
        rd(3'd4, 32'h70000007, "wr_ignored");

        send_word(32'h000003FF, 10);
        reset_n = 0;
        tick(3);
        chk("mid_rst_valid", {24'b0, row_valid}, 32'h0);
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        reset_n = 1;
        tick(2);
        rd(3'd4, 32'h0, "mid_rst_row4");
        send_word(32'h20FF000F, 32);
        do_latch();
        rd(3'd5, 32'h44445555, "post_rst_row5");
        chk("post_rst_valid", {24'b0, row_valid}, 32'h20);
        chk("post_rst_err", {24'b0, err_count}, 32'd0);
        do_latch();
        chk("empty_latch_err", {24'b0, err_count}, 32'd1);

        send_word(32'h40123456 >> 1, 31);
        mosi = 1'b0;
        tick(3);
        mclk = 1; mlatch = 1;
        tick(3);
        mclk = 0; mlatch = 0;
        tick(5);
        rd(3'd6, 32'h01270350, "same_cycle_row6");
        chk("same_cycle_valid", {24'b0, row_valid}, 32'h60);
        chk("same_cycle_err", {24'b0, err_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
